i2c_target: RTL and testbench

- I2C target (responder) for the I2C bus driven by the team's APB I2C master: 7-bit addressed, standard/fast mode, with no clock stretching.
- Decodes START, STOP and repeated-START on oversampled SCL/SDA, acknowledges its own address, and bridges I2C bytes to a simple 8-bit register-file port.
- Sits in chip I/O next to the pad cells and is used as a configuration slave or as the verification counterpart of the master controller.
- The first byte written after the address is the register pointer; later bytes write or read consecutive registers with auto-increment.

---
 rtl/i2c_target_pkg.sv | 17 +
 rtl/i2c_bus_filter.sv | 52 +++++
 rtl/i2c_target.sv | 164 ++++++++++++++++
 tb/tb_i2c_target.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C target: FSM state encoding and bit-counter width.
package i2c_target_pkg;

    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdAck,
        StIgnore
    } state_e;

endpackage

// File: rtl/i2c_bus_filter.sv
// Synchronizes and glitch-filters SCL/SDA, then derives SCL edges and START/STOP pulses.
module i2c_bus_filter #(
    parameter int unsigned FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    localparam int unsigned CNT_W = 3;

    // Index 0 carries SCL, index 1 carries SDA.
    logic [1:0]       meta_q, sync_q, filt_q, prev_q;
    logic [CNT_W-1:0] cnt_q [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
            filt_q <= 2'b11;
            prev_q <= 2'b11;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            meta_q <= {sda_in, scl_in};
            sync_q <= meta_q;
            prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_W'(FILT - 1)) begin
                    filt_q[i] <= sync_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign sda      = filt_q[1];
    assign scl_rise = filt_q[0] & ~prev_q[0];
    assign scl_fall = ~filt_q[0] & prev_q[0];
    assign start    = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
    assign stop     = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];

endmodule

// File: rtl/i2c_target.sv
// 7-bit I2C target bridging bus bytes to an 8-bit register port with pointer auto-increment.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter int unsigned FILT = 3,
    parameter int unsigned HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] my_addr,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       addressed,
    output logic       done
);

    localparam int unsigned HOLD_W = 3;

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   cnt_q;
    logic [7:0]             sr_q;
    logic                   rw_q, ptr_loaded_q, ld_q;
    logic [HOLD_W-1:0]      hold_q;
    logic                   sda, scl_rise, scl_fall, start, stop;
    logic                   drive_want, apply, last_bit;
    logic [7:0]             byte_in;

    i2c_bus_filter #(.FILT(FILT)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign sda_out  = 1'b0;
    assign byte_in  = {sr_q[6:0], sda};
    assign last_bit = (cnt_q == BIT_CNT_W'(7));
    assign apply    = (HOLD <= 1) ? scl_fall : (hold_q == HOLD_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = StIdle;
        end else if (start) begin
            state_d = StAddr;
        end else begin
            unique case (state_q)
                StAddr:    if (scl_rise && last_bit)
                               state_d = (byte_in[7:1] == my_addr) ? StAddrAck : StIgnore;
                // Reads wait for the fetched byte before driving it out.
                StAddrAck: if (rw_q ? ld_q : scl_rise) state_d = rw_q ? StRdByte : StWrByte;
                StWrByte:  if (scl_rise && last_bit) state_d = StWrAck;
                StWrAck:   if (scl_rise) state_d = StWrByte;
                StRdByte:  if (scl_rise && last_bit) state_d = StRdAck;
                StRdAck:   if (ld_q) state_d = StRdByte;
                           else if (scl_rise && sda) state_d = StIgnore;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        drive_want = 1'b0;
        unique case (state_q)
            StAddrAck, StWrAck: drive_want = 1'b1;
            StRdByte:           drive_want = ~sr_q[7];
            default:            drive_want = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_oe <= 1'b0;
            hold_q <= '0;
        end else begin
            if (scl_fall)          hold_q <= HOLD_W'(HOLD - 1);
            else if (hold_q != '0) hold_q <= hold_q - HOLD_W'(1);
            if (start || stop) sda_oe <= 1'b0;
            else if (apply)    sda_oe <= drive_want;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            sr_q         <= '0;
            rw_q         <= 1'b0;
            ptr_loaded_q <= 1'b0;
            ld_q         <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            reg_we       <= 1'b0;
            reg_re       <= 1'b0;
            busy         <= 1'b0;
            addressed    <= 1'b0;
            done         <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            done   <= 1'b0;
            ld_q   <= reg_re;
            if (reg_we) reg_addr <= reg_addr + 8'd1;
            if (stop) begin
                busy      <= 1'b0;
                addressed <= 1'b0;
                done      <= addressed;
                cnt_q     <= '0;
            end else if (start) begin
                busy      <= 1'b1;
                addressed <= 1'b0;
                cnt_q     <= '0;
            end else begin
                if (scl_rise && (state_q inside {StAddr, StWrByte, StRdByte})) begin
                    cnt_q <= cnt_q + BIT_CNT_W'(1);
                    sr_q  <= byte_in;
                end
                unique case (state_q)
                    StAddr: if (scl_rise && last_bit) begin
                        rw_q <= sda;
                        if (byte_in[7:1] == my_addr) addressed <= 1'b1;
                    end
                    StAddrAck: if (scl_rise) begin
                        if (rw_q) reg_re       <= 1'b1;
                        else      ptr_loaded_q <= 1'b0;
                    end
                    StWrByte: if (scl_rise && last_bit) begin
                        if (ptr_loaded_q) begin
                            reg_wdata <= byte_in;
                            reg_we    <= 1'b1;
                        end else begin
                            reg_addr     <= byte_in;
                            ptr_loaded_q <= 1'b1;
                        end
                    end
                    StRdAck: if (scl_rise) begin
                        reg_addr <= reg_addr + 8'd1;
                        if (!sda) reg_re <= 1'b1;
                    end
                    default: ;
                endcase
                if (ld_q) sr_q <= reg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bit-banged open-drain master plus a register-port monitor.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int Q = 20;
    localparam logic [6:0] MY_ADDR = 7'h2A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in, sda_in, sda_out, sda_oe;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_we, reg_re, busy, addressed, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int quiet_viol = 0;
    logic quiet = 1'b0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    always #5 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_target #(.FILT(3), .HOLD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .my_addr   (MY_ADDR),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_out   (sda_out),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .addressed (addressed),
        .done      (done)
    );

    // Register file model: byte at address a reads back as 0x20 + a.
    always @(posedge clk) if (reg_re) reg_rdata <= 8'h20 + reg_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] ew;
        logic [7:0]  er;
        if (!rst) begin
            if (reg_we) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected write: got addr %02h data %02h, required none",
                             reg_addr, reg_wdata);
                end else begin
                    ew = exp_wr.pop_front();
                    check("reg write addr/data", {16'h0, reg_addr, reg_wdata}, {16'h0, ew});
                end
            end
            if (reg_re) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected read: got addr %02h, required none", reg_addr);
                end else begin
                    er = exp_rd.pop_front();
                    check("reg read addr", {24'h0, reg_addr}, {24'h0, er});
                end
            end
            if (done) done_cnt++;
            if (quiet && (sda_oe || reg_we || reg_re)) quiet_viol++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; idle(Q); scl_m = 1'b1; idle(2 * Q); scl_m = 1'b0; idle(Q);
    endtask

    task automatic start_cond();
        sda_m = 1'b1; idle(Q); scl_m = 1'b1; idle(Q); sda_m = 1'b0; idle(Q); scl_m = 1'b0; idle(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; idle(Q); scl_m = 1'b1; idle(Q); sda_m = 1'b1; idle(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic ack;
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        sda_m = 1'b1; idle(Q); scl_m = 1'b1; idle(Q);
        ack = ~sda_in;
        idle(Q); scl_m = 1'b0; idle(Q);
        check(name, {31'h0, ack}, {31'h0, exp_ack});
    endtask

    task automatic recv_byte(input logic nack, input logic [7:0] exp, input string name);
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; idle(Q); scl_m = 1'b1; idle(Q);
            d[i] = sda_in;
            idle(Q); scl_m = 1'b0; idle(Q);
        end
        bit_out(nack);
        check(name, {24'h0, d}, {24'h0, exp});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        logic seen;
        idle(5);
        check("reset sda_oe", {31'h0, sda_oe}, 0);
        check("reset reg_addr", {24'h0, reg_addr}, 0);
        check("reset reg_wdata", {24'h0, reg_wdata}, 0);
        check("reset we/re/done", {29'h0, reg_we, reg_re, done}, 0);
        check("reset busy/addressed", {30'h0, busy, addressed}, 0);
        check("sda_out tied low", {31'h0, sda_out}, 0);
        rst = 1'b0;
        idle(20);

        // 1: write two registers from pointer 0x10.
        d0 = done_cnt;
        exp_wr.push_back(16'h10A5);
        exp_wr.push_back(16'h115B);
        start_cond();
        check("t1 busy after start", {31'h0, busy}, 1);
        send_byte(8'h54, 1'b1, "t1 addr ack");
        check("t1 addressed", {31'h0, addressed}, 1);
        send_byte(8'h10, 1'b1, "t1 ptr ack");
        send_byte(8'hA5, 1'b1, "t1 data0 ack");
        send_byte(8'h5B, 1'b1, "t1 data1 ack");
        stop_cond();
        idle(20);
        check("t1 reg_addr final", {24'h0, reg_addr}, 32'h12);
        check("t1 done pulses", done_cnt - d0, 1);
        check("t1 busy after stop", {31'h0, busy}, 0);
        check("t1 writes drained", exp_wr.size(), 0);

        // 2: pointer write, repeated START, three-byte read.
        d0 = done_cnt;
        exp_rd.push_back(8'h20);
        exp_rd.push_back(8'h21);
        exp_rd.push_back(8'h22);
        start_cond();
        send_byte(8'h54, 1'b1, "t2 addr ack");
        send_byte(8'h20, 1'b1, "t2 ptr ack");
        start_cond();
        check("t2 busy after Sr", {31'h0, busy}, 1);
        send_byte(8'h55, 1'b1, "t2 read addr ack");
        recv_byte(1'b0, 8'h40, "t2 read byte0");
        recv_byte(1'b0, 8'h41, "t2 read byte1");
        recv_byte(1'b1, 8'h42, "t2 read byte2");
        check("t2 sda released after nack", {31'h0, sda_oe}, 0);
        stop_cond();
        idle(20);
        check("t2 done pulses", done_cnt - d0, 1);
        check("t2 reads drained", exp_rd.size(), 0);

        // 3: foreign address stays silent.
        d0 = done_cnt;
        quiet = 1'b1;
        quiet_viol = 0;
        start_cond();
        check("t3 busy after start", {31'h0, busy}, 1);
        send_byte(8'h56, 1'b0, "t3 addr nack");
        check("t3 not addressed", {31'h0, addressed}, 0);
        send_byte(8'hFF, 1'b0, "t3 data nack");
        stop_cond();
        idle(20);
        quiet = 1'b0;
        check("t3 busy after stop", {31'h0, busy}, 0);
        check("t3 no oe/we/re", quiet_viol, 0);
        check("t3 no done", done_cnt - d0, 0);

        // 4: pointer wraps from 0xFF to 0x00.
        d0 = done_cnt;
        exp_wr.push_back(16'hFF01);
        exp_wr.push_back(16'h0002);
        start_cond();
        send_byte(8'h54, 1'b1, "t4 addr ack");
        send_byte(8'hFF, 1'b1, "t4 ptr ack");
        send_byte(8'h01, 1'b1, "t4 data0 ack");
        send_byte(8'h02, 1'b1, "t4 data1 ack");
        stop_cond();
        idle(20);
        check("t4 reg_addr wrapped", {24'h0, reg_addr}, 32'h01);
        check("t4 writes drained", exp_wr.size(), 0);
        check("t4 done pulses", done_cnt - d0, 1);

        // 5: glitches are filtered; STOP mid-byte aborts.
        sda_m = 1'b0; idle(2); sda_m = 1'b1; idle(20);
        check("t5 idle glitch no start", {31'h0, busy}, 0);
        d0 = done_cnt;
        start_cond();
        send_byte(8'h54, 1'b1, "t5 addr ack");
        send_byte(8'h40, 1'b1, "t5 ptr ack");
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        sda_m = 1'b0; idle(Q); scl_m = 1'b1; idle(Q);
        sda_m = 1'b1; idle(2); sda_m = 1'b0; idle(20);
        check("t5 high glitch no stop", {31'h0, busy}, 1);
        scl_m = 1'b0; idle(Q);
        stop_cond();
        idle(20);
        check("t5 busy after stop", {31'h0, busy}, 0);
        check("t5 addressed cleared", {31'h0, addressed}, 0);
        check("t5 sda_oe released", {31'h0, sda_oe}, 0);
        check("t5 reg_addr kept", {24'h0, reg_addr}, 32'h40);
        check("t5 done pulses", done_cnt - d0, 1);

        // 6: asynchronous reset while the ACK is driven.
        start_cond();
        for (int i = 7; i >= 0; i--) bit_out(MY_ADDR[6 - (7 - i)] & (i != 0) | 1'b0);
        sda_m = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (sda_oe) seen = 1'b1;
            else idle(1);
        end
        check("t6 ack driven before reset", {31'h0, seen}, 1);
        #3 rst = 1'b1;
        #1;
        check("t6 sda_oe drops async", {31'h0, sda_oe}, 0);
        check("t6 reset reg_addr", {24'h0, reg_addr}, 0);
        check("t6 reset busy/addressed/done", {29'h0, busy, addressed, done}, 0);
        check("t6 reset we/re", {30'h0, reg_we, reg_re}, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        idle(10);
        rst = 1'b0;
        idle(20);
        d0 = done_cnt;
        exp_wr.push_back(16'h3077);
        start_cond();
        send_byte(8'h54, 1'b1, "t6 addr ack");
        send_byte(8'h30, 1'b1, "t6 ptr ack");
        send_byte(8'h77, 1'b1, "t6 data ack");
        stop_cond();
        idle(20);
        check("t6 reg_addr final", {24'h0, reg_addr}, 32'h31);
        check("t6 writes drained", exp_wr.size(), 0);
        check("t6 done pulses", done_cnt - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
